z80_bus_master: RTL and testbench
=================================

// Module: z80_bus_master
// PURPOSE
//  Z80-bus initiator: turns single-word requests from an internal host (debug/loader/DMA) into Z80-timed
//  memory and I/O cycles (T1/T2/Tw/T3) on the board bus, so the memory mapper, window ports, system port and 16550 can be driven as targets.
//  Honours WAIT_n, times out stuck cycles, returns read data through a one-request-at-a-time handshake.
// PARAMETERS
//  CLK_DIV   8    system clocks per T-state (even, >=4); 8 -> 3 MHz bus at 24 MHz
//  MAX_WAIT  255  max Tw states before abort (counter width = clog2(MAX_WAIT+1))
// PORTS
//  CLK_24MHz  in   1   system clock; sole clock domain
//  RES        in   1   reset, synchronous, active-high
//  req_valid  in   1   request present
//  req_ready  out  1   high only in IDLE
//  req_io     in   1   1 = I/O cycle, 0 = memory cycle
//  req_wr     in   1   1 = write, 0 = read
//  req_addr   in   16  bus address
//  req_wdata  in   8   write data
//  rsp_valid  out  1   1-clock pulse, cycle finished
//  rsp_rdata  out  8   read data (held until next rsp_valid; 8'h00 after writes)
//  rsp_err    out  1   valid with rsp_valid; 1 = WAIT timeout
//  BUS_CLK    out  1   Z80 clock: 1 for phase < CLK_DIV/2, else 0; 1 when idle
//  A          out  16  address bus
//  D_OUT      out  8   data out; D_OE = drive enable (top level builds inout D)
//  D_OE       out  1
//  D_IN       in   8   data bus input
//  MREQ_n IORQ_n RD_n WR_n M1_n  out 1 each  active-low strobes; M1_n fixed 1
//  WAIT_n     in   1   async; 2-flop synchronised before use
// BEHAVIOUR
//  Reset: all strobes 1, M1_n 1, D_OE 0, A 16'h0000, D_OUT 8'h00, req_ready 1, rsp_valid 0, rsp_err 0, rsp_rdata 8'h00.
//  RES mid-cycle: strobes deasserted and D_OE 0 on the next clock, state IDLE, no rsp_valid.
//  Phase counter 0..CLK_DIV-1 per T-state; HALF = CLK_DIV/2; runs only outside IDLE.
//  FSM: IDLE -> T1 -> T2 -> [TWA if io] -> [TW]* -> T3 -> DONE -> IDLE.
//  Accept at req_valid&req_ready (clock 0): latch addr/data/kind; T1 phase 0 at clock 1; A valid from T1 phase 0 to T3 end.
//  Mem read: MREQ_n,RD_n=0 at T1 HALF; deassert at T3 HALF; D_IN latched into rsp_rdata the same clock.
//  Mem write: MREQ_n=0, D_OE=1 at T1 HALF; WR_n=0 at T2 HALF; MREQ_n/WR_n=1 at T3 HALF; D_OE=0 at T3 end.
//  I/O: IORQ_n and RD_n/WR_n=0 at T2 phase 0; one forced wait TWA always; D_OE from T1 HALF (write);
//       deassert/latch at T3 HALF as memory.
//  WAIT: synced WAIT_n sampled at last phase of T2 (mem) or TWA/TW (io and mem); 0 -> insert TW.
//  Timeout: wait count reaching MAX_WAIT -> abort: strobes and D_OE to 1/0 immediately, T3 skipped,
//   DONE with rsp_err=1, rsp_rdata 8'hFF.
//  Latency (no waits): mem rsp_valid at clock 3*CLK_DIV+1; io at 4*CLK_DIV+1; +CLK_DIV per TW.
//  DONE lasts 1 clock (rsp_valid); IDLE the next clock; back-to-back accept gives 1 idle clock between cycles.
//  req_* inputs ignored while req_ready=0; request fields never change a running cycle.
//  Strobes registered (glitch-free); MREQ_n and IORQ_n never low together.
// STRUCTURE
//  z80bd_pkg: FSM state enum (IDLE,T1,T2,TWA,TW,T3,DONE), CYC_MEM/CYC_IO constants, HALF localparam function.
//  Sub-module z80_tstate_timer: phase counter, end-of-T-state/HALF strobes, BUS_CLK generation.
//  Top: FSM, WAIT synchroniser, wait/timeout counter, bus output registers.
// TESTING
//  Mem read 0x4000, target returns 8'hA5, WAIT_n=1 -> MREQ_n/RD_n low T1 HALF..T3 HALF, rsp_rdata 8'hA5 at clock 25.
//  Mem write 0x8001 <= 8'h3C, WAIT_n=0 for 2 T-states -> WR_n low from T2 HALF, 2 TW, rsp_valid at clock 41.
//  I/O write port 16'h0020 <= 8'h02 -> IORQ_n/WR_n low from T2, one TWA, rsp_valid at clock 33, MREQ_n stays 1.
//  I/O read 16'h00EF with WAIT_n stuck 0, MAX_WAIT=4 -> abort after 4 TW, rsp_err=1, rsp_rdata 8'hFF.
//  RES pulse at T2 phase 3 of a mem write -> next clock all strobes 1, D_OE 0, req_ready 1, no rsp_valid.
//  Back-to-back mem read then io read with req_valid held -> second accept clock after DONE, strobes never overlap.

Source files
------------

// File: rtl/z80bd_pkg.sv
// Shared types and helpers for the Z80 bus initiator.
package z80bd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_T1   = 3'd1,
      ST_T2   = 3'd2,
      ST_TWA  = 3'd3,
      ST_TW   = 3'd4,
      ST_T3   = 3'd5,
      ST_DONE = 3'd6
   } state_e;

   localparam logic CYC_MEM = 1'b0;
   localparam logic CYC_IO  = 1'b1;

   // Phase index at which the falling half of a T-state begins.
   function automatic int half_of(input int clk_div);
      return clk_div / 2;
   endfunction

endpackage

// File: rtl/z80_tstate_timer.sv
// T-state phase counter: produces the "one clock before HALF" and
// "last phase" strobes for the sequencer, plus the registered Z80 clock.
module z80_tstate_timer
   import z80bd_pkg::*;
#(
   parameter int CLK_DIV = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic pre_half,
   output logic t_end,
   output logic bus_clk
);

   localparam int              HALF        = half_of(CLK_DIV);
   localparam int              PW          = $clog2(CLK_DIV);
   localparam logic [PW-1:0]   PH_LAST     = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0]   PH_PRE_HALF = PW'(HALF - 1);
   localparam logic [PW-1:0]   PH_HALF     = PW'(HALF);

   logic [PW-1:0] phase_q, phase_d;
   logic          bus_clk_q, bus_clk_d;

   // Next phase: wraps every CLK_DIV clocks while a cycle runs, parked at 0 otherwise.
   always_comb begin
      phase_d = '0;
      if (run) begin
         phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
      end
      // Registered so BUS_CLK is high for phases below HALF and while parked.
      bus_clk_d = (phase_d < PH_HALF);
   end

   // Phase and bus clock registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q   <= '0;
         bus_clk_q <= 1'b1;
      end else begin
         phase_q   <= phase_d;
         bus_clk_q <= bus_clk_d;
      end
   end

   assign pre_half = (phase_q == PH_PRE_HALF);
   assign t_end    = (phase_q == PH_LAST);
   assign bus_clk  = bus_clk_q;

endmodule

// File: rtl/z80_bus_master.sv
// Z80-bus initiator: one host request at a time becomes a Z80-timed memory
// or I/O cycle; WAIT_n stretches it, a wait timeout aborts it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request, bus quiet
// T1      | address out; mem strobes / write data enable at HALF
// T2      | io strobes at phase 0, mem WR_n at HALF, WAIT sampled (mem)
// TWA     | forced io wait state, WAIT sampled at its last phase
// TW      | inserted wait state, counts toward timeout
// T3      | strobes released and read data captured at HALF
// DONE    | one-clock response pulse
//
// All strobes are changed one clock ahead of the phase they belong to, so
// they come straight from flops and line up with the phase boundaries.
module z80_bus_master
   import z80bd_pkg::*;
#(
   parameter int CLK_DIV  = 8,
   parameter int MAX_WAIT = 255
) (
   input  logic        CLK_24MHz,
   input  logic        RES,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_io,
   input  logic        req_wr,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_err,
   output logic        BUS_CLK,
   output logic [15:0] A,
   output logic [7:0]  D_OUT,
   output logic        D_OE,
   input  logic [7:0]  D_IN,
   output logic        MREQ_n,
   output logic        IORQ_n,
   output logic        RD_n,
   output logic        WR_n,
   output logic        M1_n,
   input  logic        WAIT_n
);

   localparam int WCW = $clog2(MAX_WAIT + 1);

   state_e          state_q, state_d;
   logic            io_q, io_d;
   logic            wr_q, wr_d;
   logic [15:0]     addr_q, addr_d;
   logic [7:0]      dout_q, dout_d;
   logic            mreq_n_q, mreq_n_d;
   logic            iorq_n_q, iorq_n_d;
   logic            rd_n_q, rd_n_d;
   logic            wr_n_q, wr_n_d;
   logic            d_oe_q, d_oe_d;
   logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
   logic            rsp_err_q, rsp_err_d;
   logic [7:0]      rsp_rdata_q, rsp_rdata_d;
   logic            wait_meta_q, wait_sync_q;

   logic            run;
   logic            pre_half;
   logic            t_end;

   assign run = (state_q != ST_IDLE) && (state_q != ST_DONE);

   z80_tstate_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_timer (
      .clk      (CLK_24MHz),
      .rst      (RES),
      .run      (run),
      .pre_half (pre_half),
      .t_end    (t_end),
      .bus_clk  (BUS_CLK)
   );

   // Sequencer: next state, strobe edges, wait budget and response capture.
   always_comb begin
      state_d     = state_q;
      io_d        = io_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      dout_d      = dout_q;
      mreq_n_d    = mreq_n_q;
      iorq_n_d    = iorq_n_q;
      rd_n_d      = rd_n_q;
      wr_n_d      = wr_n_q;
      d_oe_d      = d_oe_q;
      wait_cnt_d  = wait_cnt_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d    = ST_T1;
               io_d       = req_io;
               wr_d       = req_wr;
               addr_d     = req_addr;
               dout_d     = req_wdata;
               wait_cnt_d = WCW'(MAX_WAIT);
            end
         end

         ST_T1: begin
            if (pre_half) begin
               d_oe_d = wr_q;
               if (io_q == CYC_MEM) begin
                  mreq_n_d = 1'b0;
                  rd_n_d   = wr_q;
               end
            end
            if (t_end) begin
               state_d = ST_T2;
               if (io_q == CYC_IO) begin
                  iorq_n_d = 1'b0;
                  rd_n_d   = wr_q;
                  wr_n_d   = !wr_q;
               end
            end
         end

         ST_T2: begin
            if (pre_half && (io_q == CYC_MEM) && wr_q) begin
               wr_n_d = 1'b0;
            end
            if (t_end) begin
               if (io_q == CYC_IO) begin
                  state_d = ST_TWA;
               end else if (wait_sync_q) begin
                  state_d = ST_T3;
               end else begin
                  state_d    = ST_TW;
                  wait_cnt_d = wait_cnt_q - 1'b1;
               end
            end
         end

         ST_TWA: begin
            if (t_end) begin
               if (wait_sync_q) begin
                  state_d = ST_T3;
               end else begin
                  state_d    = ST_TW;
                  wait_cnt_d = wait_cnt_q - 1'b1;
               end
            end
         end

         ST_TW: begin
            if (t_end) begin
               if (wait_sync_q) begin
                  state_d = ST_T3;
               end else if (wait_cnt_q == '0) begin
                  // Budget spent: drop the bus now and report the timeout.
                  state_d     = ST_DONE;
                  mreq_n_d    = 1'b1;
                  iorq_n_d    = 1'b1;
                  rd_n_d      = 1'b1;
                  wr_n_d      = 1'b1;
                  d_oe_d      = 1'b0;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = 8'hFF;
               end else begin
                  wait_cnt_d = wait_cnt_q - 1'b1;
               end
            end
         end

         ST_T3: begin
            if (pre_half) begin
               mreq_n_d = 1'b1;
               iorq_n_d = 1'b1;
               rd_n_d   = 1'b1;
               wr_n_d   = 1'b1;
               if (!wr_q) begin
                  rsp_rdata_d = D_IN;
               end
            end
            if (t_end) begin
               state_d   = ST_DONE;
               d_oe_d    = 1'b0;
               rsp_err_d = 1'b0;
               if (wr_q) begin
                  rsp_rdata_d = 8'h00;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, bus output and WAIT synchroniser registers.
   always_ff @(posedge CLK_24MHz) begin
      if (RES) begin
         state_q     <= ST_IDLE;
         io_q        <= CYC_MEM;
         wr_q        <= 1'b0;
         addr_q      <= 16'h0000;
         dout_q      <= 8'h00;
         mreq_n_q    <= 1'b1;
         iorq_n_q    <= 1'b1;
         rd_n_q      <= 1'b1;
         wr_n_q      <= 1'b1;
         d_oe_q      <= 1'b0;
         wait_cnt_q  <= '0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 8'h00;
         wait_meta_q <= 1'b1;
         wait_sync_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         io_q        <= io_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         dout_q      <= dout_d;
         mreq_n_q    <= mreq_n_d;
         iorq_n_q    <= iorq_n_d;
         rd_n_q      <= rd_n_d;
         wr_n_q      <= wr_n_d;
         d_oe_q      <= d_oe_d;
         wait_cnt_q  <= wait_cnt_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         wait_meta_q <= WAIT_n;
         wait_sync_q <= wait_meta_q;
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_DONE);
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign A         = addr_q;
   assign D_OUT     = dout_q;
   assign D_OE      = d_oe_q;
   assign MREQ_n    = mreq_n_q;
   assign IORQ_n    = iorq_n_q;
   assign RD_n      = rd_n_q;
   assign WR_n      = wr_n_q;
   assign M1_n      = 1'b1;

endmodule

// File: tb/tb_z80_bus_master.sv
// Bench for z80_bus_master: directed and random bus cycles compared clock by
// clock against strobe windows derived from the T-state sequence.
module tb_z80_bus_master;

   localparam int CD   = 8;
   localparam int HALF = CD / 2;
   localparam int MW   = 4;

   logic        clk = 1'b0;
   logic        res;
   logic        req_valid, req_ready, req_io, req_wr;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid, rsp_err;
   logic [7:0]  rsp_rdata;
   logic        bus_clk;
   logic [15:0] a_bus;
   logic [7:0]  d_out, d_in;
   logic        d_oe;
   logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, wait_n;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   z80_bus_master #(
      .CLK_DIV  (CD),
      .MAX_WAIT (MW)
   ) dut (
      .CLK_24MHz (clk),
      .RES       (res),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_io    (req_io),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .BUS_CLK   (bus_clk),
      .A         (a_bus),
      .D_OUT     (d_out),
      .D_OE      (d_oe),
      .D_IN      (d_in),
      .MREQ_n    (mreq_n),
      .IORQ_n    (iorq_n),
      .RD_n      (rd_n),
      .WR_n      (wr_n),
      .M1_n      (m1_n),
      .WAIT_n    (wait_n)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input bit io, input bit wr, input logic [15:0] addr, input logic [7:0] wd);
      req_io    = io;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = wd;
      req_valid = 1'b1;
   endtask

   // Runs one cycle whose request is already presented (clock 0). The target
   // holds WAIT_n low for exactly tw wait states (or forever when stuck).
   // At the response clock the next request (nv) is presented, if any.
   task automatic run_txn(input bit io, input bit wr, input logic [15:0] addr,
                          input logic [7:0] wd, input logic [7:0] din,
                          input int tw, input bit stuck,
                          input bit nv, input bit nio, input bit nwr,
                          input logic [15:0] naddr, input logic [7:0] nwd);
      int         ntw, t3, end_s, end_oe, done_pos, rel_pos, pos;
      logic [7:0] exp_rd;
      bit         ml, il, rl, wl, oe;
      ntw      = stuck ? MW : tw;
      t3       = (2 + (io ? 1 : 0) + ntw) * CD;
      end_s    = stuck ? t3 : t3 + HALF;
      end_oe   = stuck ? t3 : t3 + CD;
      done_pos = end_oe;
      rel_pos  = (io ? 3 : 2) * CD - 1 + (tw - 1) * CD + HALF;
      exp_rd   = stuck ? 8'hFF : (wr ? 8'h00 : din);
      check("ready_at_issue", 32'(req_ready), 32'd1);
      d_in   = din;
      wait_n = !stuck && (tw == 0);
      for (int k = 1; k <= done_pos + 2; k++) begin
         tick();
         pos = k - 1;
         if (!stuck && (tw > 0) && (pos == rel_pos)) wait_n = 1'b1;
         if (pos < done_pos) begin
            ml = !io && (pos >= HALF) && (pos < end_s);
            il = io && (pos >= CD) && (pos < end_s);
            rl = !wr && (pos >= (io ? CD : HALF)) && (pos < end_s);
            wl = wr && (pos >= (io ? CD : CD + HALF)) && (pos < end_s);
            oe = wr && (pos >= HALF) && (pos < end_oe);
            check("strobes", 32'({mreq_n, iorq_n, rd_n, wr_n, d_oe, m1_n}),
                  32'({!ml, !il, !rl, !wl, oe, 1'b1}));
            check("no_overlap", 32'(mreq_n | iorq_n), 32'd1);
            check("addr", 32'(a_bus), 32'(addr));
            if (oe) check("dout", 32'(d_out), 32'(wd));
            check("bus_clk", 32'(bus_clk), 32'((pos % CD) < HALF));
            check("busy", 32'({req_ready, rsp_valid}), 32'd0);
            req_valid = nv ? 1'b1 : 1'($urandom_range(0, 1));
            req_io    = 1'($urandom_range(0, 1));
            req_wr    = 1'($urandom_range(0, 1));
            req_addr  = 16'($urandom);
            req_wdata = 8'($urandom);
         end else if (pos == done_pos) begin
            check("strobes_done", 32'({mreq_n, iorq_n, rd_n, wr_n, d_oe, m1_n}), 32'h3D);
            check("rsp_valid", 32'(rsp_valid), 32'd1);
            check("rsp_err", 32'(rsp_err), 32'(stuck));
            check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
            check("ready_in_done", 32'(req_ready), 32'd0);
            req_valid = nv;
            req_io    = nio;
            req_wr    = nwr;
            req_addr  = naddr;
            req_wdata = nwd;
         end else begin
            check("rsp_single_pulse", 32'(rsp_valid), 32'd0);
            check("ready_after_done", 32'(req_ready), 32'd1);
         end
      end
   endtask

   // Reset pulse at T2 phase 3 of a memory write.
   task automatic reset_mid();
      bit seen;
      issue(1'b0, 1'b1, 16'h2222, 8'h55);
      wait_n = 1'b1;
      for (int k = 1; k <= CD + 4; k++) begin
         tick();
         if (k == 1) req_valid = 1'b0;
      end
      check("pre_res_strobes", 32'({mreq_n, iorq_n, rd_n, wr_n, d_oe, m1_n}), 32'h1F);
      res = 1'b1;
      tick();
      check("res_strobes", 32'({mreq_n, iorq_n, rd_n, wr_n, d_oe, m1_n}), 32'h3D);
      check("res_ready", 32'(req_ready), 32'd1);
      check("res_rsp", 32'(rsp_valid), 32'd0);
      res  = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (rsp_valid) seen = 1'b1;
      end
      check("res_no_rsp", 32'(seen), 32'd0);
      check("res_idle_ready", 32'(req_ready), 32'd1);
   endtask

   initial begin
      bit         cio, cwr, nio, nwr, chain, stk;
      logic [15:0] caddr, naddr;
      logic [7:0]  cwd, nwd, din;
      int          tw;

      res       = 1'b1;
      req_valid = 1'b0;
      req_io    = 1'b0;
      req_wr    = 1'b0;
      req_addr  = 16'h0000;
      req_wdata = 8'h00;
      d_in      = 8'h00;
      wait_n    = 1'b1;
      repeat (3) tick();
      check("rst_strobes", 32'({mreq_n, iorq_n, rd_n, wr_n, d_oe, m1_n}), 32'h3D);
      check("rst_addr", 32'(a_bus), 32'h0);
      check("rst_dout", 32'(d_out), 32'h0);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
      check("rst_rdata", 32'(rsp_rdata), 32'h0);
      check("rst_bus_clk", 32'(bus_clk), 32'd1);
      res = 1'b0;
      tick();

      issue(1'b0, 1'b0, 16'h4000, 8'h00);
      run_txn(1'b0, 1'b0, 16'h4000, 8'h00, 8'hA5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
      issue(1'b0, 1'b1, 16'h8001, 8'h3C);
      run_txn(1'b0, 1'b1, 16'h8001, 8'h3C, 8'h00, 2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
      issue(1'b1, 1'b1, 16'h0020, 8'h02);
      run_txn(1'b1, 1'b1, 16'h0020, 8'h02, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
      issue(1'b1, 1'b0, 16'h00EF, 8'h00);
      run_txn(1'b1, 1'b0, 16'h00EF, 8'h00, 8'h5A, 0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
      issue(1'b0, 1'b0, 16'h1234, 8'h00);
      run_txn(1'b0, 1'b0, 16'h1234, 8'h00, 8'h77, MW, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);

      reset_mid();

      issue(1'b0, 1'b0, 16'h0100, 8'h00);
      run_txn(1'b0, 1'b0, 16'h0100, 8'h00, 8'hC3, 0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h00F0, 8'h00);
      run_txn(1'b1, 1'b0, 16'h00F0, 8'h00, 8'h96, 1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);

      cio   = 1'($urandom_range(0, 1));
      cwr   = 1'($urandom_range(0, 1));
      caddr = 16'($urandom);
      cwd   = 8'($urandom);
      issue(cio, cwr, caddr, cwd);
      for (int i = 0; i < 24; i++) begin
         nio   = 1'($urandom_range(0, 1));
         nwr   = 1'($urandom_range(0, 1));
         naddr = 16'($urandom);
         nwd   = 8'($urandom);
         chain = (i < 23) && ($urandom_range(0, 1) == 1);
         din   = 8'($urandom);
         tw    = $urandom_range(0, MW);
         stk   = ($urandom_range(0, 7) == 0);
         run_txn(cio, cwr, caddr, cwd, din, tw, stk, chain, nio, nwr, naddr, nwd);
         cio   = nio;
         cwr   = nwr;
         caddr = naddr;
         cwd   = nwd;
         if (!chain && (i < 23)) issue(cio, cwr, caddr, cwd);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
